// File: rtl/quadra_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quadra_pkg
//  Description : Shared widths, coefficient types and loader state encoding
//                for the quadratic-evaluator coefficient loader.
//  Revision    : 1.0  initial release
// ============================================================================
package quadra_pkg;

    // Default geometry. The top exposes these as overridable parameters.
    localparam int DEF_X1_W   = 6;
    localparam int DEF_A_W    = 16;
    localparam int DEF_B_W    = 16;
    localparam int DEF_C_W    = 24;
    localparam int DEF_WORD_W = 32;

    typedef logic [DEF_A_W-1:0]  coef_a_t;
    typedef logic [DEF_B_W-1:0]  coef_b_t;
    typedef logic [DEF_C_W-1:0]  coef_c_t;
    typedef logic [DEF_X1_W-1:0] seg_t;

    // Loader session states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LD_A = 3'd1,
        ST_LD_B = 3'd2,
        ST_LD_C = 3'd3,
        ST_CHK  = 3'd4
    } ld_state_e;

    // Which coefficient field of a table entry a write targets.
    typedef enum logic [1:0] {
        FLD_A = 2'd0,
        FLD_B = 2'd1,
        FLD_C = 2'd2
    } field_e;

endpackage
`default_nettype wire

// File: rtl/coef_table.sv
`default_nettype none
// ============================================================================
//  Module      : coef_table
//  Description : N x (a,b,c) coefficient register array. One write port that
//                updates a single field of one entry per cycle, and one fully
//                combinational read port. Storage is intentionally not reset.
//  Ports       : clk                       clock
//                wr_en/wr_field/wr_seg     write strobe, field select, entry
//                wr_a/wr_b/wr_c            write data per field
//                rd_x1                     read entry index
//                rd_a/rd_b/rd_c            read data (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module coef_table
    import quadra_pkg::*;
#(
    parameter int X1_W = DEF_X1_W,
    parameter int A_W  = DEF_A_W,
    parameter int B_W  = DEF_B_W,
    parameter int C_W  = DEF_C_W
) (
    input  logic            clk,
    input  logic            wr_en,
    input  field_e          wr_field,
    input  logic [X1_W-1:0] wr_seg,
    input  logic [A_W-1:0]  wr_a,
    input  logic [B_W-1:0]  wr_b,
    input  logic [C_W-1:0]  wr_c,
    input  logic [X1_W-1:0] rd_x1,
    output logic [A_W-1:0]  rd_a,
    output logic [B_W-1:0]  rd_b,
    output logic [C_W-1:0]  rd_c
);

    localparam int N = 2 ** X1_W;

    logic [A_W-1:0] a_mem [N];
    logic [B_W-1:0] b_mem [N];
    logic [C_W-1:0] c_mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (wr_field)
                FLD_A:   a_mem[wr_seg] <= wr_a;
                FLD_B:   b_mem[wr_seg] <= wr_b;
                FLD_C:   c_mem[wr_seg] <= wr_c;
                default: ;
            endcase
        end
    end

    assign rd_a = a_mem[rd_x1];
    assign rd_b = b_mem[rd_x1];
    assign rd_c = c_mem[rd_x1];

endmodule
`default_nettype wire

// File: rtl/quadra_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : quadra_coef_loader
//  Description : Writer side of the quadratic-evaluator coefficient table.
//                Accepts a valid/ready word stream of N (a,b,c) triples
//                followed by an XOR checksum word, fills the table and raises
//                table_valid only when the checksum matches.
//  Ports       : clk, rst_n                clock, async active-low reset
//                start, abort              session control
//                in_valid/in_ready/in_data word stream
//                busy, done, err           session status
//                table_valid               table holds a verified set
//                rd_x1 -> rd_a/rd_b/rd_c   combinational table read
//  Revision    : 1.0  initial release
// ============================================================================
module quadra_coef_loader
    import quadra_pkg::*;
#(
    parameter int X1_W   = DEF_X1_W,
    parameter int A_W    = DEF_A_W,
    parameter int B_W    = DEF_B_W,
    parameter int C_W    = DEF_C_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              table_valid,
    input  logic [X1_W-1:0]   rd_x1,
    output logic [A_W-1:0]    rd_a,
    output logic [B_W-1:0]    rd_b,
    output logic [C_W-1:0]    rd_c
);

    localparam int MAX_COEF_W = (A_W > B_W) ? ((A_W > C_W) ? A_W : C_W)
                                            : ((B_W > C_W) ? B_W : C_W);
    localparam logic [X1_W-1:0] SEG_LAST = '1;

    generate
        if (WORD_W < MAX_COEF_W) begin : g_word_w_check
            $error("quadra_coef_loader: WORD_W narrower than widest coefficient");
        end
    endgenerate

    ld_state_e         state_q,       state_d;
    logic [X1_W-1:0]   seg_cnt_q,     seg_cnt_d;
    logic [WORD_W-1:0] chk_q,         chk_d;
    logic              err_q,         err_d;
    logic              done_q,        done_d;
    logic              table_valid_q, table_valid_d;

    logic   wr_en;
    field_e wr_field;
    logic   xfer;

    // Every non-IDLE state consumes exactly one word per transfer, so ready
    // is simply "session active".
    assign in_ready = (state_q != ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_d       = state_q;
        seg_cnt_d     = seg_cnt_q;
        chk_d         = chk_q;
        err_d         = err_q;
        done_d        = 1'b0;
        table_valid_d = table_valid_q;
        wr_en         = 1'b0;
        wr_field      = FLD_A;

        if (abort && state_q != ST_IDLE) begin
            // Abort wins over any transfer in the same cycle: nothing written.
            state_d       = ST_IDLE;
            table_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d       = ST_LD_A;
                        seg_cnt_d     = '0;
                        chk_d         = '0;
                        err_d         = 1'b0;
                        table_valid_d = 1'b0;
                    end
                end
                ST_LD_A: begin
                    if (xfer) begin
                        wr_en    = 1'b1;
                        wr_field = FLD_A;
                        chk_d    = chk_q ^ in_data;
                        state_d  = ST_LD_B;
                    end
                end
                ST_LD_B: begin
                    if (xfer) begin
                        wr_en    = 1'b1;
                        wr_field = FLD_B;
                        chk_d    = chk_q ^ in_data;
                        state_d  = ST_LD_C;
                    end
                end
                ST_LD_C: begin
                    if (xfer) begin
                        wr_en    = 1'b1;
                        wr_field = FLD_C;
                        chk_d    = chk_q ^ in_data;
                        if (seg_cnt_q == SEG_LAST) begin
                            state_d = ST_CHK;
                        end else begin
                            seg_cnt_d = seg_cnt_q + 1'b1;
                            state_d   = ST_LD_A;
                        end
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        state_d = ST_IDLE;
                        if (chk_q == in_data) begin
                            table_valid_d = 1'b1;
                            done_d        = 1'b1;
                        end else begin
                            err_d         = 1'b1;
                            table_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            seg_cnt_q     <= '0;
            chk_q         <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            table_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            seg_cnt_q     <= seg_cnt_d;
            chk_q         <= chk_d;
            err_q         <= err_d;
            done_q        <= done_d;
            table_valid_q <= table_valid_d;
        end
    end

    assign done        = done_q;
    assign err         = err_q;
    assign table_valid = table_valid_q;

    coef_table #(
        .X1_W (X1_W),
        .A_W  (A_W),
        .B_W  (B_W),
        .C_W  (C_W)
    ) u_coef_table (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_field (wr_field),
        .wr_seg   (seg_cnt_q),
        .wr_a     (in_data[A_W-1:0]),
        .wr_b     (in_data[B_W-1:0]),
        .wr_c     (in_data[C_W-1:0]),
        .rd_x1    (rd_x1),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .rd_c     (rd_c)
    );

endmodule
`default_nettype wire

// File: tb/tb_quadra_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quadra_coef_loader
//  Description : Directed self-checking bench for quadra_coef_loader with a
//                4-entry table (X1_W=2) and 32-bit load words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_quadra_coef_loader;

    localparam int X1_W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        table_valid;
    logic [1:0]  rd_x1;
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    logic [23:0] rd_c;

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;

    logic [31:0] good [13];

    quadra_coef_loader #(
        .X1_W   (X1_W),
        .A_W    (16),
        .B_W    (16),
        .C_W    (24),
        .WORD_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .table_valid (table_valid),
        .rd_x1       (rd_x1),
        .rd_a        (rd_a),
        .rd_b        (rd_b),
        .rd_c        (rd_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
    end

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0)         begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (table_valid !== 1'b0) begin errors++; $display("FAIL reset_table_valid got=%b exp=0", table_valid); end
    endtask

    task automatic test_good_load();
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL good_ready_after_start got=%b exp=1", in_ready); end
        for (int i = 0; i < 13; i++) send_word(good[i]);
        checks++; if (done !== 1'b1)        begin errors++; $display("FAIL good_done got=%b exp=1", done); end
        checks++; if (table_valid !== 1'b1) begin errors++; $display("FAIL good_table_valid got=%b exp=1", table_valid); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL good_busy got=%b exp=0", busy); end
        rd_x1 = 2'd2; #1;
        checks++; if (rd_a !== 16'h7777)   begin errors++; $display("FAIL good_rd_a2 got=%h exp=7777", rd_a); end
        checks++; if (rd_b !== 16'h8888)   begin errors++; $display("FAIL good_rd_b2 got=%h exp=8888", rd_b); end
        checks++; if (rd_c !== 24'h009999) begin errors++; $display("FAIL good_rd_c2 got=%h exp=009999", rd_c); end
        rd_x1 = 2'd0; #1;
        checks++; if (rd_a !== 16'h1111)   begin errors++; $display("FAIL good_rd_a0 got=%h exp=1111", rd_a); end
        checks++; if (rd_c !== 24'h003333) begin errors++; $display("FAIL good_rd_c0 got=%h exp=003333", rd_c); end
        rd_x1 = 2'd3; #1;
        checks++; if (rd_b !== 16'hBBBB)   begin errors++; $display("FAIL good_rd_b3 got=%h exp=bbbb", rd_b); end
        checks++; if (rd_c !== 24'h00CCCC) begin errors++; $display("FAIL good_rd_c3 got=%h exp=00cccc", rd_c); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL good_done_pulse_width got=%b exp=0", done); end
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        for (int i = 0; i < 12; i++) send_word(good[i]);
        send_word(32'hDEADBEEF);
        checks++; if (err !== 1'b1)         begin errors++; $display("FAIL bad_err got=%b exp=1", err); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL bad_done got=%b exp=0", done); end
        checks++; if (table_valid !== 1'b0) begin errors++; $display("FAIL bad_table_valid got=%b exp=0", table_valid); end
        // start clears the sticky error; abort returns to IDLE.
        pulse_start();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_clear_on_start got=%b exp=0", err); end
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        int base;
        pulse_start();
        base = xfer_cnt;
        while (idx < 13 && cyc < 400) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = good[idx];
            @(posedge clk); #1;
            if (in_valid) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1)           begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
        checks++; if (table_valid !== 1'b1)    begin errors++; $display("FAIL bp_table_valid got=%b exp=1", table_valid); end
        checks++; if (xfer_cnt - base !== 13)  begin errors++; $display("FAIL bp_xfer_count got=%0d exp=13", xfer_cnt - base); end
        rd_x1 = 2'd2; #1;
        checks++; if (rd_b !== 16'h8888) begin errors++; $display("FAIL bp_rd_b2 got=%h exp=8888", rd_b); end
    endtask

    task automatic test_abort();
        pulse_start();
        for (int i = 0; i < 5; i++) send_word(good[i]);
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (table_valid !== 1'b0) begin errors++; $display("FAIL abort_table_valid got=%b exp=0", table_valid); end
        checks++; if (err !== 1'b0)         begin errors++; $display("FAIL abort_err got=%b exp=0", err); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        pulse_start();
        for (int i = 0; i < 13; i++) send_word(good[i]);
        checks++; if (table_valid !== 1'b1) begin errors++; $display("FAIL abort_reload_table_valid got=%b exp=1", table_valid); end
    endtask

    task automatic test_start_busy();
        int base;
        pulse_start();
        for (int i = 0; i < 6; i++) send_word(good[i]);
        pulse_start();              // must not restart the session
        for (int i = 6; i < 13; i++) send_word(good[i]);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_ignored_done got=%b exp=1", done); end
        // Word offered in IDLE must not be consumed.
        base = xfer_cnt;
        in_valid = 1'b1; in_data = 32'hFFFFFFFF;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (xfer_cnt - base !== 0) begin errors++; $display("FAIL idle_xfer_count got=%0d exp=0", xfer_cnt - base); end
        // start + abort together while in LD_B.
        pulse_start();
        send_word(good[0]);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL start_abort_busy got=%b exp=0", busy); end
        checks++; if (table_valid !== 1'b0) begin errors++; $display("FAIL start_abort_table_valid got=%b exp=0", table_valid); end
    endtask

    task automatic test_async_reset();
        logic [31:0] w [13];
        logic [31:0] x;
        pulse_start();
        for (int i = 0; i < 6; i++) send_word(good[i]);
        in_valid = 1'b1; in_data = good[6];
        #2 rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL arst_err got=%b exp=0", err); end
        checks++; if (table_valid !== 1'b0) begin errors++; $display("FAIL arst_table_valid got=%b exp=0", table_valid); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        // Reload with an 'a' word whose upper bits are set.
        x = 32'h0;
        for (int i = 0; i < 12; i++) begin
            w[i] = (i == 0) ? 32'hFFFF0001 : good[i];
            x = x ^ w[i];
        end
        w[12] = x;
        pulse_start();
        for (int i = 0; i < 13; i++) send_word(w[i]);
        checks++; if (table_valid !== 1'b1) begin errors++; $display("FAIL arst_reload_table_valid got=%b exp=1", table_valid); end
        rd_x1 = 2'd0; #1;
        checks++; if (rd_a !== 16'h0001) begin errors++; $display("FAIL arst_rd_a_low_bits got=%h exp=0001", rd_a); end
    endtask

    initial begin
        for (int k = 1; k <= 12; k++) good[k-1] = k * 32'h1111;
        good[12] = 32'h0000CCCC;   // XOR of 0x1111..0xCCCC

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; rd_x1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_good_load();
        test_bad_checksum();
        test_backpressure();
        test_abort();
        test_start_busy();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
